// File: rtl/vga_tile_renderer_if.sv
// Tile RAM read port between the renderer and the external synchronous tile RAM.
//   tile_addr : 9-bit read address, driven by the renderer
//   tile_data : 4-bit tile index, returned by the RAM one clock after tile_addr
interface vga_tile_renderer_if;
    logic [8:0] tile_addr;
    logic [3:0] tile_data;

    modport master (output tile_addr, input tile_data);
    modport slave  (input tile_addr, output tile_data);
endinterface

// File: rtl/vga_tile_renderer.sv
// Pixel-colour stage placed after the VGA sync generator. It draws a 20x15 grid
// of 32x32 tiles read from an external tile RAM, with optional grid lines and a
// blinking cursor outline. rgb, hsync and vsync all leave two pixel ticks after
// their inputs, so colour and sync stay aligned.
// Ports:
//   clock, reset           : clock and asynchronous active-low reset
//   p_tick                 : pixel-rate square wave; a rising edge marks a new pixel
//   pixel_x, pixel_y       : current pixel coordinates from the sync generator
//   video_on               : display-area flag from the sync generator
//   hsync_in, vsync_in     : active-high syncs from the sync generator
//   cursor_col, cursor_row : cursor tile position, latched at each frame start
//   tram                   : tile RAM read port (address out, data back)
//   rgb                    : {R[3:0],G[3:0],B[3:0]}
//   hsync, vsync           : syncs delayed to match rgb
module vga_tile_renderer #(
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] GRID_COLOR   = 12'h444,
    parameter bit          GRID_EN      = 1'b1,
    parameter logic [11:0] CURSOR_COLOR = 12'hFFF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       p_tick,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       video_on,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic [4:0]                 cursor_col,
    input  logic [3:0]                 cursor_row,
    vga_tile_renderer_if.master        tram,
    output logic [11:0]                rgb,
    output logic                       hsync,
    output logic                       vsync
);
    localparam int unsigned    CNT_W    = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [4:0]     NUM_COLS = 5'd20;
    localparam logic [3:0]     NUM_ROWS = 4'd15;

    logic             p_tick_d;
    logic             tick;
    logic             active_in;
    logic [8:0]       addr_c;
    logic             frame_start;

    // stage 0
    logic [9:0]       s0_x;
    logic [8:0]       s0_y;
    logic             s0_active;
    logic             s0_hs;
    logic             s0_vs;
    // stage 1
    logic [11:0]      s1_rgb;
    logic             s1_hs;
    logic             s1_vs;

    logic [4:0]       cur_col;
    logic [3:0]       cur_row;
    logic [CNT_W-1:0] frame_cnt;
    logic             blink_on;

    logic [11:0]      base_c;
    logic [11:0]      color_c;
    logic             grid_hit;
    logic             cursor_hit;
    logic             edge_x;
    logic             edge_y;

    function automatic logic [3:0] chan(input logic sel, input logic bright);
        return sel ? (bright ? 4'hF : 4'h8) : 4'h0;
    endfunction

    // Tick detect, local active-area check, and tile address = row*20 + col
    always_comb begin
        tick        = p_tick & ~p_tick_d;
        active_in   = video_on && (pixel_x < 10'd640) && (pixel_y < 10'd480);
        addr_c      = (9'(pixel_y[8:5]) << 4) + (9'(pixel_y[8:5]) << 2) + 9'(pixel_x[9:5]);
        frame_start = tick & vsync_in & ~s0_vs;
    end

    // Colour decision for the pixel held in stage 0; tile_data is valid by now
    always_comb begin
        base_c     = BG_COLOR;
        color_c    = 12'h000;
        edge_x     = (s0_x[4:1] == 4'h0) || (s0_x[4:1] == 4'hF);
        edge_y     = (s0_y[4:1] == 4'h0) || (s0_y[4:1] == 4'hF);
        grid_hit   = (s0_x[4:0] == 5'd0) || (s0_y[4:0] == 5'd0);
        cursor_hit = (cur_col < NUM_COLS) && (cur_row < NUM_ROWS)
                     && (s0_x[9:5] == cur_col) && (s0_y[8:5] == cur_row)
                     && (edge_x || edge_y);

        if (tram.tile_data != 4'h0) begin
            base_c = {chan(tram.tile_data[2], tram.tile_data[3]),
                      chan(tram.tile_data[1], tram.tile_data[3]),
                      chan(tram.tile_data[0], tram.tile_data[3])};
        end

        if (!s0_active) begin
            color_c = 12'h000;
        end else if (cursor_hit && blink_on) begin
            color_c = CURSOR_COLOR;
        end else if (GRID_EN && grid_hit) begin
            color_c = GRID_COLOR;
        end else begin
            color_c = base_c;
        end
    end

    // Pipeline, frame counter and cursor latch; all stages hold between ticks
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_tick_d       <= 1'b1;
            s0_x           <= '0;
            s0_y           <= '0;
            s0_active      <= 1'b0;
            s0_hs          <= 1'b0;
            s0_vs          <= 1'b0;
            tram.tile_addr <= '0;
            s1_rgb         <= '0;
            s1_hs          <= 1'b0;
            s1_vs          <= 1'b0;
            rgb            <= '0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
            cur_col        <= '0;
            cur_row        <= '0;
            frame_cnt      <= '0;
            blink_on       <= 1'b1;
        end else begin
            p_tick_d <= p_tick;
            if (tick) begin
                s0_x           <= pixel_x;
                s0_y           <= pixel_y[8:0];
                s0_active      <= active_in;
                s0_hs          <= hsync_in;
                s0_vs          <= vsync_in;
                tram.tile_addr <= active_in ? addr_c : 9'd0;
                s1_rgb         <= color_c;
                s1_hs          <= s0_hs;
                s1_vs          <= s0_vs;
                rgb            <= s1_rgb;
                hsync          <= s1_hs;
                vsync          <= s1_vs;
            end
            // Cursor is latched once per frame so a mid-frame move cannot tear
            if (frame_start) begin
                cur_col <= cursor_col;
                cur_row <= cursor_row;
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer: reset, address map, colour/latency,
// overlay priority, blink/cursor latch and out-of-range cursor.
module tb_vga_tile_renderer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p_tick = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [4:0]  cursor_col = '0;
    logic [3:0]  cursor_row = '0;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    int n_chk = 0;
    int n_bad = 0;

    logic [3:0] mem [0:511];

    vga_tile_renderer_if tif ();

    vga_tile_renderer #(
        .BG_COLOR     (12'h000),
        .GRID_COLOR   (12'h444),
        .GRID_EN      (1'b1),
        .CURSOR_COLOR (12'hFFF),
        .BLINK_FRAMES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .tram       (tif.master),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    always #5 clock = ~clock;

    // Synchronous tile RAM: data one clock after address
    always_ff @(posedge clock) tif.tile_data <= mem[tif.tile_addr];

    typedef struct {
        int          x;
        int          y;
        logic        von;
        logic        hs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tab [14] = '{
        '{ 40,  40, 1'b1, 1'b1, 12'hFF0},
        '{ 72,  40, 1'b1, 1'b0, 12'h080},
        '{104,  40, 1'b1, 1'b1, 12'h000},
        '{ 10,  10, 1'b1, 1'b0, 12'h00F},
        '{ 42,  10, 1'b1, 1'b1, 12'h888},
        '{ 64,  40, 1'b1, 1'b0, 12'h444},
        '{  5,   0, 1'b1, 1'b1, 12'hFFF},
        '{ 40,  40, 1'b0, 1'b0, 12'h000},
        '{640,  40, 1'b1, 1'b1, 12'h000},
        '{ 40, 480, 1'b1, 1'b0, 12'h000},
        '{ 31,  20, 1'b1, 1'b1, 12'hFFF},
        '{  2,   2, 1'b1, 1'b0, 12'h00F},
        '{700, 500, 1'b0, 1'b0, 12'h000},
        '{700, 500, 1'b0, 1'b0, 12'h000}
    };

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One pixel: p_tick high for one clock, low for two
    task automatic pix(input int x, input int y, input logic von, input logic hs, input logic vs);
        @(negedge clock);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        @(negedge clock);
        p_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic filler();
        pix(700, 500, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probe(input int x, input int y, input logic [11:0] exp, input string tag);
        pix(x, y, 1'b1, 1'b0, 1'b0);
        filler();
        filler();
        check(tag, 16'(rgb), 16'(exp));
    endtask

    // vsync rising edge, checking the output appears exactly two ticks later
    task automatic frame_pulse();
        pix(700, 500, 1'b0, 1'b0, 1'b1);
        check("vs_lat0", 16'(vsync), 16'h0);
        filler();
        check("vs_lat1", 16'(vsync), 16'h0);
        filler();
        check("vs_lat2", 16'(vsync), 16'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 4'h0;
        mem[0]   = 4'h9;
        mem[1]   = 4'h7;
        mem[21]  = 4'hE;
        mem[22]  = 4'h2;
        mem[299] = 4'h4;

        // Held in reset while ticks run
        for (int i = 0; i < 3; i++) pix(64, 32, 1'b1, 1'b1, 1'b1);
        check("rst_rgb",   16'(rgb),           16'h0);
        check("rst_hs",    16'(hsync),         16'h0);
        check("rst_vs",    16'(vsync),         16'h0);
        check("rst_addr",  16'(tif.tile_addr), 16'h0);

        // Release with p_tick already high: no advance
        @(negedge clock);
        vsync_in = 1'b0;
        p_tick   = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rel_noadv", 16'(tif.tile_addr), 16'h0);
        p_tick = 1'b0;

        // Address map
        pix(64, 32, 1'b1, 1'b0, 1'b0);
        check("addr_64_32", 16'(tif.tile_addr), 16'd22);
        pix(0, 0, 1'b1, 1'b0, 1'b0);
        check("addr_0_0", 16'(tif.tile_addr), 16'd0);
        pix(639, 479, 1'b1, 1'b0, 1'b0);
        check("addr_639_479", 16'(tif.tile_addr), 16'd299);
        pix(640, 100, 1'b1, 1'b0, 1'b0);
        check("addr_640", 16'(tif.tile_addr), 16'd0);
        filler();
        check("rgb_639_479", 16'(rgb), 16'h800);
        filler();
        check("rgb_640", 16'(rgb), 16'h000);

        // Colour, priority and two-tick latency stream
        for (int i = 0; i < 14; i++) begin
            pix(tab[i].x, tab[i].y, tab[i].von, tab[i].hs, 1'b0);
            if (i >= 2) begin
                check($sformatf("rgb_v%0d", i - 2), 16'(rgb),   16'(tab[i-2].rgb));
                check($sformatf("hs_v%0d", i - 2),  16'(hsync), 16'(tab[i-2].hs));
            end
        end

        // Reset mid-frame: immediate clear, no stale colour afterwards
        pix(40, 40, 1'b1, 1'b1, 1'b0);
        filler();
        filler();
        check("pre_rst_rgb", 16'(rgb), 16'hFF0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_rgb", 16'(rgb),   16'h0);
        check("mid_rst_hs",  16'(hsync), 16'h0);
        @(negedge clock);
        reset = 1'b1;
        pix(10, 10, 1'b1, 1'b0, 1'b0);
        check("post_rst_0", 16'(rgb), 16'h0);
        filler();
        check("post_rst_1", 16'(rgb), 16'h0);
        filler();
        check("post_rst_2", 16'(rgb), 16'h00F);

        // Blink with BLINK_FRAMES=2: phase toggles every second frame start
        cursor_col = 5'd1;
        cursor_row = 4'd1;
        frame_pulse();
        probe(32, 40, 12'hFFF, "blink_f1");
        frame_pulse();
        probe(32, 40, 12'h444, "blink_f2");
        frame_pulse();
        probe(32, 40, 12'h444, "blink_f3");
        frame_pulse();
        probe(32, 40, 12'hFFF, "blink_f4");

        // Mid-frame cursor move waits for the next frame start
        cursor_col = 5'd2;
        probe(32, 40, 12'hFFF, "latch_old_hit");
        probe(64, 40, 12'h444, "latch_new_wait");
        frame_pulse();
        probe(64, 40, 12'hFFF, "latch_new_hit");
        probe(32, 40, 12'h444, "latch_old_gone");

        // Out-of-range cursor column: no outline anywhere on row 1 borders
        cursor_col = 5'd25;
        cursor_row = 4'd1;
        frame_pulse();
        frame_pulse();
        for (int c = 0; c < 20; c++) probe(c * 32, 33, 12'h444, $sformatf("oor_c%0d", c));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Pixel-colour stage directly downstream of the VGA sync generator; consumes its pixel coordinates, video-on, sync and pixel-tick outputs.
- Renders a 20x15 grid of 32x32-pixel tiles from an external synchronous tile RAM, with optional grid lines and a blinking cursor outline.
- Drives 12-bit RGB plus hsync/vsync, all delayed by the same number of pixel ticks, so colour and sync stay aligned at the VGA connector.

Parameters:
BG_COLOR, 12'h000, RGB for tile index 0
GRID_COLOR, 12'h444, RGB for grid-line pixels
GRID_EN, 1, 1 = draw grid lines
CURSOR_COLOR, 12'hFFF, RGB for cursor outline
BLINK_FRAMES, 30, frames per cursor blink half-period (1..63)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
p_tick  in  1  pixel-rate square wave from sync generator; rising edge = new pixel
pixel_x  in  10  current horizontal count
pixel_y  in  10  current vertical count
video_on  in  1  sync generator display-area flag
hsync_in  in  1  sync generator hsync, active-high
vsync_in  in  1  sync generator vsync, active-high
cursor_col  in  5  cursor tile column
cursor_row  in  4  cursor tile row
tile_addr  out  9  tile RAM read address
tile_data  in  4  tile RAM read data, valid 1 clock after tile_addr
rgb  out  12  {R[3:0],G[3:0],B[3:0]}
hsync  out  1  aligned hsync
vsync  out  1  aligned vsync

Behaviour:
- Reset (reset low, async): all pipeline registers, rgb, hsync, vsync, tile_addr = 0; frame counter = 0; blink phase = 1 (cursor visible); latched cursor = (0,0); tick-edge register = 1 so no tick is inferred in the first clock after reset.
- Tick detect: tick = p_tick & ~p_tick_d (registered). Pipeline advances only on cycles where tick is high; otherwise all stages hold.
- Active = video_on & (pixel_x < 640) & (pixel_y < 480). The local range check is mandatory; video_on alone is not trusted at x=640 or y=480.
- Stage 0 (tick N): register x, y, active, hsync_in, vsync_in. col = pixel_x[9:5], row = pixel_y[8:5]. tile_addr = row*20 + col, computed as (row<<4)+(row<<2)+col, 9 bits, range 0..299. tile_addr = 0 when not active.
- Stage 1 (tick N+1): tile_data is valid by this cycle because at least 2 clocks separate ticks. Base colour: index 0 gives BG_COLOR. Otherwise each channel is 0 when its select bit is 0, else 4'hF when tile_data[3]=1 and 4'h8 when tile_data[3]=0. Select bits: R = tile_data[2], G = tile_data[1], B = tile_data[0].
- Overlay priority, highest first:
  1. not active: rgb = 0
  2. cursor pixel with blink phase 1: CURSOR_COLOR
  3. grid pixel with GRID_EN: GRID_COLOR
  4. base colour
- Grid pixel: x[4:0]==0 or y[4:0]==0.
- Cursor pixel: col == latched cursor_col, row == latched cursor_row, and x[4:0] in {0,1,30,31} or y[4:0] in {0,1,30,31}.
- Stage 2 (tick N+2): rgb, hsync, vsync registered outputs. Total latency is 2 ticks for colour and sync alike.
- Frame events: a frame start is the rising edge of the stage-0 registered vsync.
  - At frame start, latch cursor_col and cursor_row, so a mid-frame cursor change never tears.
  - At frame start, the frame counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- Cursor out of range (latched col >= 20 or row >= 15): no cursor drawn; no other effect.
- Reset asserted mid-frame: outputs drop to 0 immediately. After release, output resumes 2 ticks after the first tick; no stale colour appears.

Test Plan:
- Reset low while p_tick toggles: rgb = 0, hsync = vsync = 0, tile_addr = 0. Release reset with p_tick already high: no pipeline advance until the next rising p_tick.
- Address map: x=0,y=0 gives tile_addr=0. x=639,y=479 gives 299. x=64,y=32 gives 22. x=640 with video_on=1 gives tile_addr=0 and rgb=0 two ticks later.
- Latency and colour: tile_data=4'hE at x=40,y=40, GRID_EN=0. Exactly 2 ticks later rgb=12'hFF0; hsync/vsync equal their inputs from 2 ticks earlier. tile_data=4'h2 gives 12'h080. tile_data=0 gives BG_COLOR.
- Priority: cursor=(1,1), x=32,y=40, blink phase 1: rgb=CURSOR_COLOR although the grid is also hit. Same pixel with blink phase 0: GRID_COLOR.
- Blink and latch, with BLINK_FRAMES=2: phase toggles on every 2nd vsync rising edge. A cursor_col change mid-frame takes effect only after the next vsync rising edge.
- Out-of-range cursor (col=25): no CURSOR_COLOR on any pixel over a full frame.
